cache: RTL and testbench

Direct-mapped, write-back, write-allocate cache sitting between the pipelined MIPS core and a slow block-oriented memory inside `CHIP`. It is instantiated twice: as `I_cache`, read-only in practice, and as `D_cache`. It serves 32-bit word requests from the core, stalls the core on a miss, and moves whole 128-bit blocks to and from `slow_memory` with a level request / `mem_ready` handshake.

---
 rtl/cache_pkg.sv | 37 +++
 rtl/cache_if.sv | 29 ++
 rtl/cache.sv | 139 +++++++++++++
 tb/tb_cache.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache:
// geometry constants, FSM state type and block word helpers.
package cache_pkg;

   localparam int unsigned NUM_BLOCKS  = 8;
   localparam int unsigned WORDS       = 4;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned OFF_W       = 2;
   localparam int unsigned TAG_W       = 25;
   localparam int unsigned BLK_W       = WORDS * WORD_W;
   localparam int unsigned PROC_ADDR_W = TAG_W + IDX_W + OFF_W;
   localparam int unsigned MEM_ADDR_W  = TAG_W + IDX_W;

   typedef enum logic [1:0] {
      StIdle,
      StWriteback,
      StAllocate
   } cache_state_e;

   // Pick one 32-bit word out of a block; word 0 sits in the low bits.
   function automatic logic [WORD_W-1:0] word_sel(logic [BLK_W-1:0] blk,
                                                   logic [OFF_W-1:0] off);
      return blk[off*WORD_W +: WORD_W];
   endfunction

   // Return the block with one word replaced.
   function automatic logic [BLK_W-1:0] word_put(logic [BLK_W-1:0]  blk,
                                                 logic [OFF_W-1:0]  off,
                                                 logic [WORD_W-1:0] w);
      logic [BLK_W-1:0] r;
      r = blk;
      r[off*WORD_W +: WORD_W] = w;
      return r;
   endfunction

endpackage

// File: rtl/cache_if.sv
// Core-side request bus and memory-side block bus of the cache.
// slave: the cache's view; master: the core/memory environment's view.
interface cache_if;

   logic                                  proc_read;
   logic                                  proc_write;
   logic [cache_pkg::PROC_ADDR_W-1:0]     proc_addr;
   logic [cache_pkg::WORD_W-1:0]          proc_wdata;
   logic [cache_pkg::WORD_W-1:0]          proc_rdata;
   logic                                  proc_stall;

   logic                                  mem_read;
   logic                                  mem_write;
   logic [cache_pkg::MEM_ADDR_W-1:0]      mem_addr;
   logic [cache_pkg::BLK_W-1:0]           mem_wdata;
   logic [cache_pkg::BLK_W-1:0]           mem_rdata;
   logic                                  mem_ready;

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate cache: 8 lines x 4 words.
// Hits complete with no stall; misses stall the core while a dirty victim
// is written back and the missing block is fetched.
module cache
   import cache_pkg::*;
(
   input logic    clk,
   input logic    rst_n,
   cache_if.slave bus
);

   logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
   logic [BLK_W-1:0]      data_q [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] valid_q;
   logic [NUM_BLOCKS-1:0] dirty_q;

   cache_state_e          state_q, state_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [BLK_W-1:0]      mem_wdata_q, mem_wdata_d;

   logic [OFF_W-1:0]      offset;
   logic [IDX_W-1:0]      index;
   logic [TAG_W-1:0]      tag;
   logic                  request;
   logic                  hit;
   logic                  in_idle;
   logic                  write_hit;
   logic                  fill;
   logic                  wb_done;

   assign offset  = bus.proc_addr[OFF_W-1:0];
   assign index   = bus.proc_addr[IDX_W+OFF_W-1:OFF_W];
   assign tag     = bus.proc_addr[PROC_ADDR_W-1:IDX_W+OFF_W];

   assign request   = bus.proc_read | bus.proc_write;
   assign hit       = valid_q[index] & (tag_q[index] == tag);
   assign in_idle   = (state_q == StIdle);
   // A simultaneous read and write is treated as a write.
   assign write_hit = in_idle & bus.proc_write & hit;
   assign fill      = (state_q == StAllocate) & bus.mem_ready;
   assign wb_done   = (state_q == StWriteback) & bus.mem_ready;

   assign bus.proc_stall = request & (~in_idle | ~hit);
   assign bus.proc_rdata = word_sel(data_q[index], offset);

   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // State and registered memory request; reset abandons any transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next state plus the memory request to present in that state.
   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         StIdle: begin
            if (request && !hit) begin
               if (valid_q[index] && dirty_q[index]) begin
                  state_d     = StWriteback;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_q[index], index};
                  mem_wdata_d = data_q[index];
               end else begin
                  state_d    = StAllocate;
                  mem_read_d = 1'b1;
                  mem_addr_d = {tag, index};
               end
            end
         end
         StWriteback: begin
            if (bus.mem_ready) begin
               state_d     = StAllocate;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = {tag, index};
            end
         end
         StAllocate: begin
            if (bus.mem_ready) begin
               state_d    = StIdle;
               mem_read_d = 1'b0;
            end
         end
         default: begin
            state_d     = StIdle;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   // Line status bits: set on fill, dirtied by write hits, cleaned by writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (write_hit) begin
         dirty_q[index] <= 1'b1;
      end else if (wb_done) begin
         dirty_q[index] <= 1'b0;
      end
   end

   // Tag and data storage; contents are meaningless until valid is set.
   always_ff @(posedge clk) begin
      if (fill) begin
         data_q[index] <= bus.mem_rdata;
         tag_q[index]  <= tag;
      end else if (write_hit) begin
         data_q[index] <= word_put(data_q[index], offset, bus.proc_wdata);
      end
   end

endmodule

// File: tb/tb_cache.sv
// Bench for the cache: an 8-cycle slow memory, a reference memory model with
// expected line residency, a per-cycle comparator and directed accesses.
module tb_cache;
   import cache_pkg::*;

   localparam int MEM_LAT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   cache_if bus();

   cache dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Backing store of the slow memory and the core-visible reference memory.
   logic [127:0] bmem    [logic [27:0]];
   logic [31:0]  ref_mem [logic [29:0]];

   function automatic logic [31:0] init_word(logic [29:0] a);
      return 32'hA500_0000 | {2'b00, a};
   endfunction

   function automatic logic [127:0] bmem_block(logic [27:0] b);
      logic [127:0] blk;
      if (bmem.exists(b)) return bmem[b];
      for (int w = 0; w < 4; w++) blk[w*32 +: 32] = init_word({b, 2'(w)});
      return blk;
   endfunction

   function automatic logic [31:0] ref_word(logic [29:0] a);
      logic [127:0] blk;
      if (ref_mem.exists(a)) return ref_mem[a];
      blk = bmem_block(a[29:2]);
      return blk[a[1:0]*32 +: 32];
   endfunction

   function automatic logic [127:0] ref_block(logic [27:0] b);
      logic [127:0] blk;
      for (int w = 0; w < 4; w++) blk[w*32 +: 32] = ref_word({b, 2'(w)});
      return blk;
   endfunction

   // Expected residency and miss bookkeeping.
   bit           m_valid [8];
   bit           m_dirty [8];
   logic [24:0]  m_tag   [8];
   bit           busy, exp_wb, wb_seen, fire;
   int           cnt;
   int           n_rd, n_wr;
   logic [27:0]  last_rd_addr, last_wr_addr;
   logic [127:0] last_wr_data;
   logic [29:0]  ca;
   logic [2:0]   cidx;
   logic [24:0]  ctg;
   bit           creq, chit;

   // Slow memory responder and per-cycle comparator.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.mem_ready = 1'b0;
         cnt  = 0;
         busy = 0;
         for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
         end
         ref_mem.delete();
      end else begin
         if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            cnt = 0;
         end
         fire = 0;
         if (bus.mem_read || bus.mem_write) begin
            cnt++;
            if (cnt == MEM_LAT) begin
               fire = 1;
               bus.mem_ready = 1'b1;
               if (!bus.mem_write) bus.mem_rdata = bmem_block(bus.mem_addr);
            end
         end
         if (bus.mem_read) begin
            n_rd++;
            last_rd_addr = bus.mem_addr;
         end
         if (bus.mem_write) begin
            n_wr++;
            last_wr_addr = bus.mem_addr;
            last_wr_data = bus.mem_wdata;
         end

         ca   = bus.proc_addr;
         cidx = ca[4:2];
         ctg  = ca[29:5];
         creq = bus.proc_read || bus.proc_write;
         chit = m_valid[cidx] && (m_tag[cidx] == ctg);
         if (!busy) begin
            chk("idle_mem_req", {bus.mem_read, bus.mem_write}, 2'b00);
            if (creq) begin
               chk("stall", bus.proc_stall, !chit);
               if (chit) begin
                  if (bus.proc_write) begin
                     ref_mem[ca]    = bus.proc_wdata;
                     m_dirty[cidx]  = 1;
                  end else begin
                     chk("rdata", bus.proc_rdata, ref_word(ca));
                  end
               end else begin
                  busy    = 1;
                  exp_wb  = m_valid[cidx] && m_dirty[cidx];
                  wb_seen = 0;
               end
            end else begin
               chk("stall_noreq", bus.proc_stall, 1'b0);
            end
         end else begin
            chk("stall_busy", bus.proc_stall, 1'b1);
            chk("mem_onehot", bus.mem_read ^ bus.mem_write, 1'b1);
            if (bus.mem_write) begin
               chk("wb_expected", exp_wb && !wb_seen, 1'b1);
               chk("wb_addr", bus.mem_addr, {m_tag[cidx], cidx});
               chk("wb_data", bus.mem_wdata, ref_block({m_tag[cidx], cidx}));
               if (bus.mem_ready) begin
                  wb_seen       = 1;
                  m_dirty[cidx] = 0;
               end
            end else if (bus.mem_read) begin
               chk("alloc_order", wb_seen, exp_wb);
               chk("alloc_addr", bus.mem_addr, {ctg, cidx});
               if (bus.mem_ready) begin
                  m_valid[cidx] = 1;
                  m_tag[cidx]   = ctg;
                  m_dirty[cidx] = 0;
                  busy          = 0;
               end
            end
         end
         if (fire && bus.mem_write) bmem[bus.mem_addr] = bus.mem_wdata;
      end
   end

   // One core access, held until the cache stops stalling; ends at posedge+1.
   task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                         output int stalls, output logic [31:0] rd);
      bus.proc_read  = !wr;
      bus.proc_write = wr;
      bus.proc_addr  = a;
      bus.proc_wdata = d;
      stalls = 0;
      rd     = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (!bus.proc_stall) begin
            rd = bus.proc_rdata;
            @(posedge clk);
            #1;
            bus.proc_read  = 1'b0;
            bus.proc_write = 1'b0;
            return;
         end
         stalls++;
      end
      checks++;
      errors++;
      $display("FAIL access_timeout: addr=%0h still stalled after %0d cycles", a, stalls);
      @(posedge clk);
      #1;
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   int           st, r0, w0;
   logic [31:0]  rd;
   logic [127:0] blk;

   initial begin
      n_rd = 0;
      n_wr = 0;
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
      bus.proc_addr  = '0;
      bus.proc_wdata = '0;
      bus.mem_rdata  = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_stall", bus.proc_stall, 1'b0);
      chk("rst_mem_read", bus.mem_read, 1'b0);
      chk("rst_mem_write", bus.mem_write, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 28'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
      bus.proc_read = 1'b1;
      #1;
      chk("rst_stall_req", bus.proc_stall, 1'b1);
      bus.proc_read = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Cold miss on block 0.
      r0 = n_rd; w0 = n_wr;
      access(0, 30'h0, 32'h0, st, rd);
      chk("miss0_stalls", st, 9);
      chk("miss0_rdata", rd, 32'hA500_0000);
      chk("miss0_rd_cycles", n_rd - r0, 8);
      chk("miss0_wr_cycles", n_wr - w0, 0);
      chk("miss0_addr", last_rd_addr, 28'h0);

      // Remaining words of block 0 hit.
      r0 = n_rd;
      for (int i = 1; i < 4; i++) begin
         access(0, 30'(i), 32'h0, st, rd);
         chk("hit_stalls", st, 0);
         chk("hit_rdata", rd, 32'hA500_0000 + 32'(i));
      end
      chk("hit_no_mem", n_rd - r0, 0);

      // Write hit then read back.
      access(1, 30'h2, 32'hDEAD_BEEF, st, rd);
      chk("whit_stalls", st, 0);
      access(0, 30'h2, 32'h0, st, rd);
      chk("whit_readback", rd, 32'hDEAD_BEEF);

      // Conflict miss on a dirty line: writeback then allocate.
      r0 = n_rd; w0 = n_wr;
      access(0, 30'h20, 32'h0, st, rd);
      chk("dirty_stalls", st, 17);
      chk("dirty_wr_cycles", n_wr - w0, 8);
      chk("dirty_rd_cycles", n_rd - r0, 8);
      chk("dirty_wb_addr", last_wr_addr, 28'h0);
      chk("dirty_wb_word2", last_wr_data[95:64], 32'hDEAD_BEEF);
      chk("dirty_alloc_addr", last_rd_addr, 28'h8);
      chk("dirty_rdata", rd, 32'hA500_0020);
      blk = bmem_block(28'h0);
      chk("mem_block0_word2", blk[95:64], 32'hDEAD_BEEF);

      // Write miss on a clean (invalid) line: allocate only.
      w0 = n_wr;
      access(1, 30'h44, 32'h1234_5678, st, rd);
      chk("wmiss_stalls", st, 9);
      chk("wmiss_no_wb", n_wr - w0, 0);
      chk("wmiss_alloc_addr", last_rd_addr, 28'h11);
      access(0, 30'h44, 32'h0, st, rd);
      chk("wmiss_readback", rd, 32'h1234_5678);
      chk("wmiss_read_stalls", st, 0);

      // Evict the line dirtied by the write miss.
      access(0, 30'h64, 32'h0, st, rd);
      chk("evict_stalls", st, 17);
      chk("evict_wb_addr", last_wr_addr, 28'h11);
      chk("evict_wb_word0", last_wr_data[31:0], 32'h1234_5678);
      chk("evict_rdata", rd, 32'hA500_0064);
      access(1, 30'h65, 32'hCAFE_F00D, st, rd);
      chk("w65_stalls", st, 0);

      // Reset in the middle of an allocate.
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h80;
      repeat (4) @(negedge clk);
      #2;
      chk("pre_rst_mem_read", bus.mem_read, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_read", bus.mem_read, 1'b0);
      chk("async_rst_mem_write", bus.mem_write, 1'b0);
      chk("async_rst_stall", bus.proc_stall, 1'b1);
      bus.proc_read = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Everything misses again; the dirty word at 0x65 was dropped.
      w0 = n_wr;
      access(0, 30'h65, 32'h0, st, rd);
      chk("post_rst_65_stalls", st, 9);
      chk("post_rst_65_rdata", rd, 32'hA500_0065);
      access(0, 30'h2, 32'h0, st, rd);
      chk("post_rst_2_stalls", st, 9);
      chk("post_rst_2_rdata", rd, 32'hDEAD_BEEF);
      access(0, 30'h44, 32'h0, st, rd);
      chk("post_rst_44_stalls", st, 9);
      chk("post_rst_44_rdata", rd, 32'h1234_5678);
      chk("post_rst_no_wb", n_wr - w0, 0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
